// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency cache-line memory responder for the
// pmem_read/pmem_write/pmem_resp handshake, backed by an internal line store.
// Optional build macro: PMEM_PROTOCOL_CHECK_EN adds the sticky proto_err output.
module pmem_line_responder #(
   parameter int unsigned LINE_W      = 256,
   parameter int unsigned OFFSET_BITS = 5,
   parameter int unsigned IDX_BITS    = 4,
   parameter int unsigned LATENCY     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [31:0]       pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp
`ifdef PMEM_PROTOCOL_CHECK_EN
   ,
   output logic              proto_err
`endif
);

   localparam int unsigned DEPTH = 1 << IDX_BITS;
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic                resp_q, resp_d;
   logic                store_we_c;

   logic [LINE_W-1:0]   store_q [DEPTH];

   // Next-state, request latch, completion pulse and read-data capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      resp_d     = 1'b0;
      store_we_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pmem_read || pmem_write) begin
               // write wins when both are raised together
               wr_d    = pmem_write;
               idx_d   = pmem_address[OFFSET_BITS +: IDX_BITS];
               wdata_d = pmem_wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            store_we_c = wr_q;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      resp_d = (state_d == S_RESP);
      // read data is registered on entry to RESP so it is stable for the pulse
      if ((state_d == S_RESP) && !wr_d) begin
         rdata_d = store_q[idx_d];
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
      end
   end

   // Line store: not reset; a write commits at the end of its RESP cycle
   always_ff @(posedge clk) begin
      if (store_we_c) begin
         store_q[idx_q] <= wdata_q;
      end
   end

   assign pmem_rdata = rdata_q;
   assign pmem_resp  = resp_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
   logic [31:0] addr_q, addr_d;
   logic        proto_err_q, proto_err_d;

   // Sticky detection of initiator handshake violations
   always_comb begin
      addr_d      = addr_q;
      proto_err_d = proto_err_q;
      if ((state_q == S_IDLE) && (pmem_read || pmem_write)) begin
         addr_d = pmem_address;
      end
      if ((state_q == S_IDLE) && pmem_read && pmem_write) begin
         proto_err_d = 1'b1;
      end
      if ((state_q == S_BUSY) && !(pmem_read || pmem_write)) begin
         proto_err_d = 1'b1;
      end
      if ((state_q == S_BUSY) && (pmem_address != addr_q)) begin
         proto_err_d = 1'b1;
      end
   end

   // Protocol checker registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         proto_err_q <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;
`else
   // offset and alias bits of the address are intentionally ignored
   logic unused_addr;
   assign unused_addr = ^pmem_address;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: a LATENCY=4 instance (d=0) and a LATENCY=1
// instance (d=1) share clk/rst_n; read data is checked through per-instance
// expectation queues popped on pmem_resp.
module tb_pmem_line_responder;

   localparam int unsigned LW = 256;

   typedef struct packed {
      logic          is_read;
      logic [LW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd [2];
   logic          wr [2];
   logic [31:0]   addr [2];
   logic [LW-1:0] wd [2];
   logic [LW-1:0] rdata [2];
   logic          resp [2];
`ifdef PMEM_PROTOCOL_CHECK_EN
   logic          perr [2];
`endif

   int tests_run = 0;
   int tests_failed = 0;

   exp_t q0[$];
   exp_t q1[$];
   logic [LW-1:0] mdl [2][16];

   always #5 clk = ~clk;

   pmem_line_responder #(.LINE_W(LW), .OFFSET_BITS(5), .IDX_BITS(4), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_address(addr[0]),
      .pmem_wdata(wd[0]), .pmem_rdata(rdata[0]), .pmem_resp(resp[0])
`ifdef PMEM_PROTOCOL_CHECK_EN
      , .proto_err(perr[0])
`endif
   );

   pmem_line_responder #(.LINE_W(LW), .OFFSET_BITS(5), .IDX_BITS(4), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_address(addr[1]),
      .pmem_wdata(wd[1]), .pmem_rdata(rdata[1]), .pmem_resp(resp[1])
`ifdef PMEM_PROTOCOL_CHECK_EN
      , .proto_err(perr[1])
`endif
   );

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Scoreboard for the LATENCY=4 instance
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && resp[0]) begin
         if (q0.size() == 0) chk("spurious_resp0", 256'(1), 256'(0));
         else begin
            e = q0.pop_front();
            if (e.is_read) chk("rdata0", rdata[0], e.data);
         end
      end
   end

   // Scoreboard for the LATENCY=1 instance
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && resp[1]) begin
         if (q1.size() == 0) chk("spurious_resp1", 256'(1), 256'(0));
         else begin
            e = q1.pop_front();
            if (e.is_read) chk("rdata1", rdata[1], e.data);
         end
      end
   end

   // One full handshake; called inside an IDLE cycle, returns in the next IDLE cycle
   task automatic do_op(input int d, input logic w, input logic r, input logic [31:0] a,
                        input logic [LW-1:0] wdat, input int lat, input string tag);
      exp_t e;
      logic [3:0] idx;
      int k;
      logic seen;
      idx = a[8:5];
      e.is_read = !w;
      e.data = mdl[d][idx];
      if (w) mdl[d][idx] = wdat;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = wdat;
      k = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (resp[d]) seen = 1'b1;
      end
      chk({tag, "_seen"}, 256'(seen), 256'(1));
      chk({tag, "_lat"}, 256'(k), 256'(lat));
      if (seen) begin
         @(posedge clk); #1;
      end
      rd[d] = 1'b0; wr[d] = 1'b0;
      chk({tag, "_pulse"}, 256'(resp[d]), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] pat_a5;
      logic [LW-1:0] v;
      pat_a5 = {32{8'hA5}};
      for (int d = 0; d < 2; d++) begin
         rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0;
      end
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) mdl[d][i] = '0;

      // reset values
      #12;
      chk("rst_resp0", 256'(resp[0]), 256'(0));
      chk("rst_rdata0", rdata[0], '0);
      chk("rst_resp1", 256'(resp[1]), 256'(0));
      chk("rst_rdata1", rdata[1], '0);
`ifdef PMEM_PROTOCOL_CHECK_EN
      chk("rst_perr0", 256'(perr[0]), 256'(0));
`endif
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: write then read idx 2
      do_op(0, 1'b1, 1'b0, 32'h0000_0040, pat_a5, 4, "t1_wr");
      do_op(0, 1'b0, 1'b1, 32'h0000_0040, '0, 4, "t1_rd");

      // 2: write idx 3, read it back with no idle gap; read data held across a write
      do_op(0, 1'b1, 1'b0, 32'h0000_0060, {8{32'hDEAD_BEEF}}, 4, "t2_wr");
      chk("t2_rdata_hold", rdata[0], pat_a5);
      do_op(0, 1'b0, 1'b1, 32'h0000_0060, '0, 4, "t2_rd");

      // 3: aliased address with offset bits set maps to idx 2
      do_op(0, 1'b0, 1'b1, 32'h0000_025F, '0, 4, "t3_alias");
      do_op(0, 1'b0, 1'b1, 32'hFFFF_FC5F, '0, 4, "t3_alias_hi");

      // 4: read and write together -> write performed
      do_op(0, 1'b1, 1'b1, 32'h0000_0080, LW'(32'h1234), 4, "t4_rw");
      do_op(0, 1'b0, 1'b1, 32'h0000_0080, '0, 4, "t4_rd");
`ifdef PMEM_PROTOCOL_CHECK_EN
      chk("t4_perr", 256'(perr[0]), 256'(1));
      repeat (3) @(posedge clk);
      #1;
      chk("t4_perr_sticky", 256'(perr[0]), 256'(1));
`endif

      // 5: reset two cycles into a write of idx 5
      do_op(0, 1'b1, 1'b0, 32'h0000_00A0, LW'(32'h5555), 4, "t5_pre");
      do_op(0, 1'b0, 1'b1, 32'h0000_00A0, '0, 4, "t5_rd_pre");
      wr[0] = 1'b1; addr[0] = 32'h0000_00A0; wd[0] = LW'(32'hFFFF);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_resp", 256'(resp[0]), 256'(0));
      chk("t5_rst_rdata", rdata[0], '0);
      wr[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_rst_resp_hold", 256'(resp[0]), 256'(0));
`ifdef PMEM_PROTOCOL_CHECK_EN
      chk("t5_perr_cleared", 256'(perr[0]), 256'(0));
`endif
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("t5_no_resp", 256'(resp[0]), 256'(0));
      do_op(0, 1'b0, 1'b1, 32'h0000_00A0, '0, 4, "t5_rd");

      // 6: LATENCY=1, fill ten lines then ten back-to-back reads
      for (int i = 0; i < 10; i++) begin
         v = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
         do_op(1, 1'b1, 1'b0, 32'(i) << 5, v, 1, "t6_wr");
      end
      for (int i = 0; i < 10; i++) begin
         do_op(1, 1'b0, 1'b1, (32'(i) << 5) | 32'h0000_0007, '0, 1, "t6_rd");
      end

      repeat (4) @(posedge clk);
      #1;
      chk("q0_drained", 256'(q0.size()), 256'(0));
      chk("q1_drained", 256'(q1.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
